// File: rtl/dmem_pkg.sv
// Shared types and helpers for the M-stage data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

   localparam int WAIT_W = 3;

   function automatic logic [31:0] wordIndex(input logic [31:0] addr);
      return addr >> 2;
   endfunction

   // Word-only bus: any low address bit set, or past the last word, is an error.
   function automatic logic addrError(input logic [31:0] addr, input int depth);
      return (addr[1:0] != 2'b00) || (addr >= 32'(4 * depth));
   endfunction

endpackage

// File: rtl/dmem_if.sv
// M-stage <-> data-memory request/response bundle; req_be exists only with DMEM_BYTE_EN.
interface dmem_if;
   import dmem_pkg::*;

   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
`ifdef DMEM_BYTE_EN
   logic [3:0]  req_be;
`endif
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        stall_m;

   modport master (
`ifdef DMEM_BYTE_EN
      output req_be,
`endif
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall_m
   );

   modport slave (
`ifdef DMEM_BYTE_EN
      input  req_be,
`endif
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, stall_m
   );

endinterface

// File: rtl/dmem_array.sv
// Word-organised data RAM: synchronous write with byte-lane enables, synchronous read.
module dmem_array #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wrEn,
   input  logic          rdEn,
   input  logic [3:0]    byteEn,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wrData,
   output logic [31:0]   rdData
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wrEn) begin
         for (int i = 0; i < 4; i++) begin
            if (byteEn[i]) mem[addr][8*i +: 8] <= wrData[8*i +: 8];
         end
      end
      if (rdEn) rdData <= mem[addr];
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accept, WAIT_STATES wait cycles, one-cycle response; stalls the pipe while busy.
// Build with DMEM_BYTE_EN for per-byte store enables; otherwise stores write whole words.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH       = 64,
   parameter int WAIT_STATES = 1
) (
   input  logic    clk,
   input  logic    reset,
   dmem_if.slave   bus
);

   localparam int AW = $clog2(DEPTH);

   dmem_state_t       state;
   logic [WAIT_W-1:0] cnt;
   logic              weLat;
   logic [31:0]       addrLat;
   logic [31:0]       wdataLat;
`ifdef DMEM_BYTE_EN
   logic [3:0]        beLat;
`endif
   logic              rspValid;
   logic              rspErr;
   logic              rspLoad;
   logic [31:0]       ramRdata;

   logic              idle;
   logic              curWe;
   logic [31:0]       curAddr;
   logic [31:0]       curWdata;
   logic [3:0]        curBe;
   logic              curErr;
   logic              enterResp;
   logic              ramWe;
   logic              ramRe;
   logic [AW-1:0]     ramAddr;

   // With zero wait states the RAM is accessed in the accept cycle, before the latches fill.
   assign idle     = (state == IDLE);
   assign curWe    = idle ? bus.req_we    : weLat;
   assign curAddr  = idle ? bus.req_addr  : addrLat;
   assign curWdata = idle ? bus.req_wdata : wdataLat;
`ifdef DMEM_BYTE_EN
   assign curBe    = idle ? bus.req_be    : beLat;
`else
   assign curBe    = 4'hF;
`endif
   assign curErr   = addrError(curAddr, DEPTH);

   assign enterResp = (idle && bus.req_valid && (WAIT_STATES == 0)) ||
                      ((state == WAIT) && (cnt == WAIT_W'(1)));

   // A reset landing on the commit edge drops the store.
   assign ramWe   = enterResp && curWe && !curErr && reset;
   assign ramRe   = enterResp && !curWe && !curErr;
   assign ramAddr = AW'(wordIndex(curAddr));

   dmem_array #(.DEPTH(DEPTH)) u_array (
      .clk    (clk),
      .wrEn   (ramWe),
      .rdEn   (ramRe),
      .byteEn (curBe),
      .addr   (ramAddr),
      .wrData (curWdata),
      .rdData (ramRdata)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         rspValid <= 1'b0;
         rspErr   <= 1'b0;
         rspLoad  <= 1'b0;
      end else begin
         rspValid <= enterResp;
         rspErr   <= enterResp && curErr;
         rspLoad  <= enterResp && !curWe && !curErr;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  weLat    <= bus.req_we;
                  addrLat  <= bus.req_addr;
                  wdataLat <= bus.req_wdata;
`ifdef DMEM_BYTE_EN
                  beLat    <= bus.req_be;
`endif
                  cnt      <= WAIT_W'(WAIT_STATES);
                  state    <= (WAIT_STATES == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - WAIT_W'(1);
               if (cnt == WAIT_W'(1)) state <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = idle && bus.req_valid;
   assign bus.rsp_valid = rspValid;
   assign bus.rsp_err   = rspErr;
   assign bus.rsp_rdata = rspLoad ? ramRdata : 32'h0;
   assign bus.stall_m   = bus.req_valid && !rspValid;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with one wait state, one with none, shared reset.
module tb_dmem_responder;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dmem_if bus0 ();
   dmem_if bus1 ();

   dmem_responder #(.DEPTH(64), .WAIT_STATES(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
   dmem_responder #(.DEPTH(64), .WAIT_STATES(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

   logic        dv  [2];
   logic        dwe [2];
   logic [31:0] dad [2];
   logic [31:0] dwd [2];
   logic [3:0]  dbe [2];
   logic        orv [2];
   logic        ordy[2];
   logic        oerr[2];
   logic        ostl[2];
   logic [31:0] ord [2];

   assign bus0.req_valid = dv[0];
   assign bus0.req_we    = dwe[0];
   assign bus0.req_addr  = dad[0];
   assign bus0.req_wdata = dwd[0];
   assign bus1.req_valid = dv[1];
   assign bus1.req_we    = dwe[1];
   assign bus1.req_addr  = dad[1];
   assign bus1.req_wdata = dwd[1];
`ifdef DMEM_BYTE_EN
   assign bus0.req_be    = dbe[0];
   assign bus1.req_be    = dbe[1];
`endif
   assign orv[0]  = bus0.rsp_valid;
   assign ordy[0] = bus0.req_ready;
   assign oerr[0] = bus0.rsp_err;
   assign ostl[0] = bus0.stall_m;
   assign ord[0]  = bus0.rsp_rdata;
   assign orv[1]  = bus1.rsp_valid;
   assign ordy[1] = bus1.req_ready;
   assign oerr[1] = bus1.rsp_err;
   assign ostl[1] = bus1.stall_m;
   assign ord[1]  = bus1.rsp_rdata;

   int nChk  = 0;
   int nPass = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChk++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Transaction-level model: a request is served once the responder is free, answered
   // W+1 cycles later; memory is updated/read at the moment the answer is formed.
   int          waitN  [2] = '{1, 0};
   int          freeAt [2] = '{0, 0};
   int          respAt [2] = '{-1, -1};
   logic        mWe    [2];
   logic [31:0] mAddr  [2];
   logic [31:0] mWd    [2];
   logic [3:0]  mBe    [2];
   logic        mErr   [2];
   logic [31:0] mRd    [2];
   bit          mRdOk  [2];
   logic [31:0] mem    [2][64];
   bit          known  [2][64];
   bit          chkOn  = 0;

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         bit eRv;
         int w;
         eRv = (respAt[k] == cyc);
         if (chkOn) begin
            chk($sformatf("rsp_valid[%0d]@%0d", k, cyc), orv[k], eRv);
            chk($sformatf("req_ready[%0d]@%0d", k, cyc), ordy[k], dv[k] && (cyc >= freeAt[k]));
            chk($sformatf("stall_m[%0d]@%0d", k, cyc), ostl[k], dv[k] && !eRv);
            if (eRv) begin
               chk($sformatf("rsp_err[%0d]@%0d", k, cyc), oerr[k], mErr[k]);
               if (mRdOk[k]) chk($sformatf("rsp_rdata[%0d]@%0d", k, cyc), ord[k], mRd[k]);
            end
         end
         if (!reset) begin
            respAt[k] = -1;
            freeAt[k] = cyc + 1;
            chkOn     = 1;
         end else begin
            if (dv[k] && (cyc >= freeAt[k])) begin
               respAt[k] = cyc + waitN[k] + 1;
               freeAt[k] = cyc + waitN[k] + 2;
               mWe[k]    = dwe[k];
               mAddr[k]  = dad[k];
               mWd[k]    = dwd[k];
`ifdef DMEM_BYTE_EN
               mBe[k]    = dbe[k];
`else
               mBe[k]    = 4'hF;
`endif
               mErr[k]   = (dad[k] % 4 != 0) || (dad[k] >= 4 * 64);
            end
            if (respAt[k] == cyc + 1) begin
               mRd[k]   = 32'h0;
               mRdOk[k] = 1;
               if (!mErr[k]) begin
                  w = int'(mAddr[k] / 4);
                  if (mWe[k]) begin
                     for (int i = 0; i < 4; i++)
                        if (mBe[k][i]) mem[k][w][8*i +: 8] = mWd[k][8*i +: 8];
                     if (mBe[k] == 4'hF) known[k][w] = 1;
                  end else begin
                     mRd[k]   = mem[k][w];
                     mRdOk[k] = known[k][w];
                  end
               end
            end
         end
      end
   end

   task automatic doReq(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output logic err,
                        output int lat, output int stalls, output logic rdy0);
      int start;
      bit got;
      @(posedge clk); #1;
      dv[k] = 1'b1; dwe[k] = we; dad[k] = addr; dwd[k] = wd; dbe[k] = be;
      start = cyc; got = 0; stalls = 0; rd = '0; err = 1'b0; lat = -1; rdy0 = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (n == 0) rdy0 = ordy[k];
         if (orv[k]) begin
            got = 1; rd = ord[k]; err = oerr[k]; lat = cyc - start;
         end else if (ostl[k]) begin
            stalls++;
         end
      end
      chk($sformatf("rsp_seen[%0d] addr %h", k, addr), got, 1'b1);
      @(posedge clk); #1;
      dv[k] = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic        err;
      logic        r0;
      int          lat;
      int          st;
      logic [5:0]  rvBits;
      logic [5:0]  stBits;

      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         dv[k] = 1'b0; dwe[k] = 1'b0; dad[k] = '0; dwd[k] = '0; dbe[k] = 4'hF;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset rsp_valid", orv[0], 1'b0);
      chk("reset rsp_err", oerr[0], 1'b0);
      chk("reset rsp_rdata", ord[0], 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;

      doReq(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, err, lat, st, r0);
      chk("t1 ready at accept", r0, 1'b1);
      chk("t1 stall cycles", st, 2);
      chk("t1 latency", lat, 2);
      chk("t1 err", err, 1'b0);

      doReq(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, err, lat, st, r0);
      chk("t2 rdata", rd, 32'hDEADBEEF);
      chk("t2 latency", lat, 2);

      doReq(0, 1'b1, 32'hFC, 32'h13579BDF, 4'hF, rd, err, lat, st, r0);
      doReq(0, 1'b0, 32'hFC, 32'h0, 4'hF, rd, err, lat, st, r0);
      chk("top word rdata", rd, 32'h13579BDF);
      chk("top word err", err, 1'b0);

      doReq(0, 1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, rd, err, lat, st, r0);
      chk("t3 misaligned err", err, 1'b1);
      chk("t3 misaligned rdata", rd, 32'h0);
      doReq(0, 1'b0, 32'h100, 32'h0, 4'hF, rd, err, lat, st, r0);
      chk("t3 range err", err, 1'b1);
      chk("t3 range rdata", rd, 32'h0);
      doReq(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, err, lat, st, r0);
      chk("t3 ram unchanged", rd, 32'hDEADBEEF);

      doReq(0, 1'b1, 32'h20, 32'h0BADF00D, 4'hF, rd, err, lat, st, r0);
      @(posedge clk); #1;
      dv[0] = 1'b1; dwe[0] = 1'b1; dad[0] = 32'h20; dwd[0] = 32'h12345678;
      @(posedge clk); #1;
      reset = 1'b0; dv[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t4 rsp_valid", orv[0], 1'b0);
      chk("t4 rsp_err", oerr[0], 1'b0);
      chk("t4 rsp_rdata", ord[0], 32'h0);
      chk("t4 stall_m", ostl[0], 1'b0);
      @(posedge clk); #1;
      reset = 1'b1;
      doReq(0, 1'b0, 32'h20, 32'h0, 4'hF, rd, err, lat, st, r0);
      chk("t4 store dropped", rd, 32'h0BADF00D);

      doReq(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, rd, err, lat, st, r0);
      chk("t6 store latency", lat, 1);
      doReq(1, 1'b0, 32'h40, 32'h0, 4'hF, rd, err, lat, st, r0);
      chk("t6 load rdata", rd, 32'hCAFEF00D);
      @(posedge clk); #1;
      dv[1] = 1'b1; dwe[1] = 1'b0; dad[1] = 32'h40;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         rvBits[i] = orv[1];
         stBits[i] = ostl[1];
      end
      @(posedge clk); #1;
      dv[1] = 1'b0;
      chk("t6 rsp_valid pattern", rvBits, 6'b101010);
      chk("t6 stall pattern", stBits, 6'b010101);

`ifdef DMEM_BYTE_EN
      doReq(0, 1'b1, 32'h30, 32'hAABBCCDD, 4'hF, rd, err, lat, st, r0);
      doReq(0, 1'b1, 32'h30, 32'h00000011, 4'b0001, rd, err, lat, st, r0);
      doReq(0, 1'b0, 32'h30, 32'h0, 4'hF, rd, err, lat, st, r0);
      chk("t5 byte merge", rd, 32'hAABBCC11);
      doReq(0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'b0000, rd, err, lat, st, r0);
      chk("t5 be0 err", err, 1'b0);
      chk("t5 be0 latency", lat, 2);
      doReq(0, 1'b0, 32'h30, 32'h0, 4'hF, rd, err, lat, st, r0);
      chk("t5 be0 no write", rd, 32'hAABBCC11);
`endif

      repeat (3) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", nPass, nChk);
      $finish;
   end

endmodule
